// File: rtl/mips_id_ex_stage_pkg.sv
// Shared types and constants for the MIPS ID/EX stage and its forwarding units.
// The optional feature macro is MIPS_FORWARDING_EN; it is consumed by the stage files.
package mips_id_ex_stage_pkg;

    localparam int Data_Width     = 32;
    localparam int Reg_Addr_Width = 5;

    typedef enum logic [3:0] {
        ADD_ALU_Sel = 4'd0,
        SUB_ALU_Sel = 4'd1,
        AND_ALU_Sel = 4'd2,
        OR_ALU_Sel  = 4'd3,
        XOR_ALU_Sel = 4'd4,
        NOR_ALU_Sel = 4'd5,
        SLT_ALU_Sel = 4'd6,
        SLL_ALU_Sel = 4'd7,
        SRL_ALU_Sel = 4'd8,
        SRA_ALU_Sel = 4'd9,
        LUI_ALU_Sel = 4'd10
    } alu_sel_t;

    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_EXM  = 2'd1,
        FWD_MWB  = 2'd2
    } fwd_sel_t;

    // Register 0 is hard-wired, so a write aimed at it never matches a reader.
    function automatic logic addr_match(
        input logic                      we,
        input logic [Reg_Addr_Width-1:0] dest,
        input logic [Reg_Addr_Width-1:0] src
    );
        return we && (dest == src) && (src != {Reg_Addr_Width{1'b0}});
    endfunction

endpackage

// File: rtl/mips_id_ex_stage_if.sv
// Decode-to-stage and stage-to-ALU channels of the ID/EX stage.
// master = environment (decode + EX), slave = the ID/EX stage itself.
interface mips_id_ex_stage_if
    import mips_id_ex_stage_pkg::*;
();
    logic                      in_valid;
    logic                      in_ready;
    alu_sel_t                  in_alu_sel;
    logic [Reg_Addr_Width-1:0] in_rs_addr;
    logic [Reg_Addr_Width-1:0] in_rt_addr;
    logic [Data_Width-1:0]     in_rs_data;
    logic [Data_Width-1:0]     in_rt_data;
    logic [Data_Width-1:0]     in_imm;
    logic                      in_use_imm;
    logic [4:0]                in_shamt;
    logic [Reg_Addr_Width-1:0] in_dest_addr;
    logic                      in_reg_write;
    logic                      in_is_load;

    logic                      out_valid;
    logic                      out_ready;
    alu_sel_t                  alu_sel;
    logic [Data_Width-1:0]     data_in1;
    logic [Data_Width-1:0]     data_in2;
    logic [4:0]                shamt;
    logic [Reg_Addr_Width-1:0] dest_addr;
    logic                      reg_write;
    logic                      is_load;

    modport master (
        output in_valid, in_alu_sel, in_rs_addr, in_rt_addr, in_rs_data, in_rt_data,
               in_imm, in_use_imm, in_shamt, in_dest_addr, in_reg_write, in_is_load, out_ready,
        input  in_ready, out_valid, alu_sel, data_in1, data_in2, shamt, dest_addr, reg_write, is_load
    );

    modport slave (
        input  in_valid, in_alu_sel, in_rs_addr, in_rt_addr, in_rs_data, in_rt_data,
               in_imm, in_use_imm, in_shamt, in_dest_addr, in_reg_write, in_is_load, out_ready,
        output in_ready, out_valid, alu_sel, data_in1, data_in2, shamt, dest_addr, reg_write, is_load
    );

endinterface

// File: rtl/mips_id_ex_stage_fwd_unit.sv
// Per-operand forwarding compare and 3:1 source mux (EX/MEM > MEM/WB > register file).
// With MIPS_FORWARDING_EN undefined any pending writer match becomes a stall instead.
module mips_fwd_unit
    import mips_id_ex_stage_pkg::*;
(
    input  logic [Reg_Addr_Width-1:0] src_addr,
    input  logic                      src_used,
    input  logic [Data_Width-1:0]     rf_data,
    input  logic                      exm_reg_write,
    input  logic [Reg_Addr_Width-1:0] exm_dest_addr,
    input  logic [Data_Width-1:0]     exm_data,
    input  logic                      exm_load,
    input  logic                      mwb_reg_write,
    input  logic [Reg_Addr_Width-1:0] mwb_dest_addr,
    input  logic [Data_Width-1:0]     mwb_data,
    output logic [Data_Width-1:0]     operand,
    output logic                      hazard
);

    logic     exm_hit_s;
    logic     mwb_hit_s;
    fwd_sel_t fwd_sel_s;

    // Match detection, source selection and stall request for this operand.
    always_comb begin
        exm_hit_s = src_used && addr_match(exm_reg_write, exm_dest_addr, src_addr);
        mwb_hit_s = src_used && addr_match(mwb_reg_write, mwb_dest_addr, src_addr);
`ifdef MIPS_FORWARDING_EN
        if (exm_hit_s) begin
            fwd_sel_s = FWD_EXM;
        end else if (mwb_hit_s) begin
            fwd_sel_s = FWD_MWB;
        end else begin
            fwd_sel_s = FWD_NONE;
        end
        // A load result is not available until it reaches MEM/WB.
        hazard = exm_hit_s && exm_load;
`else
        fwd_sel_s = FWD_NONE;
        hazard    = (exm_hit_s && exm_load) || exm_hit_s || mwb_hit_s;
`endif
        case (fwd_sel_s)
            FWD_EXM: operand = exm_data;
            FWD_MWB: operand = mwb_data;
            default: operand = rf_data;
        endcase
    end

endmodule

// File: rtl/mips_id_ex_stage.sv
// ID/EX pipeline register feeding the MIPS ALU: hazard stall, operand forwarding, flush.
// Define MIPS_FORWARDING_EN to enable forwarding and held-entry snooping of MEM/WB.
module mips_id_ex_stage
    import mips_id_ex_stage_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    mips_id_ex_stage_if.slave         bus,
    input  logic                      flush,
    input  logic                      exm_reg_write,
    input  logic [Reg_Addr_Width-1:0] exm_dest_addr,
    input  logic [Data_Width-1:0]     exm_data,
    input  logic                      exm_load,
    input  logic                      mwb_reg_write,
    input  logic [Reg_Addr_Width-1:0] mwb_dest_addr,
    input  logic [Data_Width-1:0]     mwb_data
);

    logic [Data_Width-1:0]     rs_operand_s, rt_operand_s;
    logic                      rs_hazard_s, rt_hazard_s;
    logic                      hazard_s, ready_s, capture_s;

    logic                      out_valid_r;
    alu_sel_t                  alu_sel_r;
    logic [Data_Width-1:0]     data_in1_r, data_in2_r;
    logic [4:0]                shamt_r;
    logic [Reg_Addr_Width-1:0] dest_addr_r;
    logic                      reg_write_r, is_load_r;

    mips_fwd_unit u_rs_fwd (
        .src_addr(bus.in_rs_addr), .src_used(1'b1), .rf_data(bus.in_rs_data),
        .exm_reg_write(exm_reg_write), .exm_dest_addr(exm_dest_addr), .exm_data(exm_data),
        .exm_load(exm_load), .mwb_reg_write(mwb_reg_write), .mwb_dest_addr(mwb_dest_addr),
        .mwb_data(mwb_data), .operand(rs_operand_s), .hazard(rs_hazard_s)
    );

    mips_fwd_unit u_rt_fwd (
        .src_addr(bus.in_rt_addr), .src_used(!bus.in_use_imm), .rf_data(bus.in_rt_data),
        .exm_reg_write(exm_reg_write), .exm_dest_addr(exm_dest_addr), .exm_data(exm_data),
        .exm_load(exm_load), .mwb_reg_write(mwb_reg_write), .mwb_dest_addr(mwb_dest_addr),
        .mwb_data(mwb_data), .operand(rt_operand_s), .hazard(rt_hazard_s)
    );

    // Handshake: flush always drains the input, otherwise stall on hazard or a held entry.
    always_comb begin
        hazard_s  = rs_hazard_s || rt_hazard_s;
        ready_s   = flush || (!hazard_s && (!out_valid_r || bus.out_ready));
        capture_s = bus.in_valid && ready_s && !flush;
    end

`ifdef MIPS_FORWARDING_EN
    logic [Reg_Addr_Width-1:0] held_rs_r, held_rt_r;
    logic                      held_use_imm_r;
    logic                      rs_snoop_s, rt_snoop_s;

    // Source tags of the captured entry, used to refresh it while EX is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_rs_r      <= {Reg_Addr_Width{1'b0}};
            held_rt_r      <= {Reg_Addr_Width{1'b0}};
            held_use_imm_r <= 1'b0;
        end else if (capture_s) begin
            held_rs_r      <= bus.in_rs_addr;
            held_rt_r      <= bus.in_rt_addr;
            held_use_imm_r <= bus.in_use_imm;
        end
    end

    // MEM/WB writes that land on a held operand's source register.
    always_comb begin
        rs_snoop_s = addr_match(mwb_reg_write, mwb_dest_addr, held_rs_r);
        rt_snoop_s = !held_use_imm_r && addr_match(mwb_reg_write, mwb_dest_addr, held_rt_r);
    end
`endif

    // Pipeline register: flush > capture > consume > hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            alu_sel_r   <= ADD_ALU_Sel;
            data_in1_r  <= {Data_Width{1'b0}};
            data_in2_r  <= {Data_Width{1'b0}};
            shamt_r     <= 5'd0;
            dest_addr_r <= {Reg_Addr_Width{1'b0}};
            reg_write_r <= 1'b0;
            is_load_r   <= 1'b0;
        end else if (flush) begin
            out_valid_r <= 1'b0;
            reg_write_r <= 1'b0;
        end else if (capture_s) begin
            out_valid_r <= 1'b1;
            alu_sel_r   <= bus.in_alu_sel;
            data_in1_r  <= rs_operand_s;
            data_in2_r  <= bus.in_use_imm ? bus.in_imm : rt_operand_s;
            shamt_r     <= bus.in_shamt;
            dest_addr_r <= bus.in_dest_addr;
            reg_write_r <= bus.in_reg_write;
            is_load_r   <= bus.in_is_load;
        end else if (out_valid_r && bus.out_ready) begin
            out_valid_r <= 1'b0;
        end
`ifdef MIPS_FORWARDING_EN
        else if (out_valid_r) begin
            if (rs_snoop_s) data_in1_r <= mwb_data;
            if (rt_snoop_s) data_in2_r <= mwb_data;
        end
`endif
    end

    assign bus.in_ready  = ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.alu_sel   = alu_sel_r;
    assign bus.data_in1  = data_in1_r;
    assign bus.data_in2  = data_in2_r;
    assign bus.shamt     = shamt_r;
    assign bus.dest_addr = dest_addr_r;
    assign bus.reg_write = reg_write_r;
    assign bus.is_load   = is_load_r;

endmodule

// File: tb/tb_mips_id_ex_stage.sv
// Self-checking bench for mips_id_ex_stage: directed scenarios plus randomized traffic
// against a behavioural model; expectations follow the MIPS_FORWARDING_EN build setting.
module tb_mips_id_ex_stage;
    import mips_id_ex_stage_pkg::*;

`ifdef MIPS_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        exm_reg_write = 1'b0;
    logic [4:0]  exm_dest_addr = 5'd0;
    logic [31:0] exm_data = 32'd0;
    logic        exm_load = 1'b0;
    logic        mwb_reg_write = 1'b0;
    logic [4:0]  mwb_dest_addr = 5'd0;
    logic [31:0] mwb_data = 32'd0;

    mips_id_ex_stage_if bus ();

    mips_id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .flush(flush),
        .exm_reg_write(exm_reg_write), .exm_dest_addr(exm_dest_addr),
        .exm_data(exm_data), .exm_load(exm_load),
        .mwb_reg_write(mwb_reg_write), .mwb_dest_addr(mwb_dest_addr), .mwb_data(mwb_data)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model of the visible stage contents.
    logic        m_valid;
    alu_sel_t    m_alu;
    logic [31:0] m_d1, m_d2;
    logic [4:0]  m_shamt, m_dest, m_rs, m_rt;
    logic        m_rw, m_ld, m_imm;

    function automatic bit hits(logic we, logic [4:0] dest, logic [4:0] src);
        return we && (dest == src) && (src != 5'd0);
    endfunction

    function automatic bit blocked(logic [4:0] src);
        if (FWD) return hits(exm_reg_write, exm_dest_addr, src) && exm_load;
        return hits(exm_reg_write, exm_dest_addr, src) || hits(mwb_reg_write, mwb_dest_addr, src);
    endfunction

    function automatic logic [31:0] resolve(logic [4:0] src, logic [31:0] rf);
        if (FWD && hits(exm_reg_write, exm_dest_addr, src)) return exm_data;
        if (FWD && hits(mwb_reg_write, mwb_dest_addr, src)) return mwb_data;
        return rf;
    endfunction

    function automatic bit model_ready();
        bit haz;
        haz = blocked(bus.in_rs_addr) || (!bus.in_use_imm && blocked(bus.in_rt_addr));
        return flush || (!haz && (!m_valid || bus.out_ready));
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_alu = ADD_ALU_Sel; m_d1 = 32'd0; m_d2 = 32'd0;
        m_shamt = 5'd0; m_dest = 5'd0; m_rs = 5'd0; m_rt = 5'd0;
        m_rw = 1'b0; m_ld = 1'b0; m_imm = 1'b0;
    endtask

    // Advance one clock, updating the model from the inputs present before the edge.
    task automatic tick();
        bit f, take, hold;
        logic [31:0] n_d1, n_d2, s_d1, s_d2;
        f    = flush;
        take = bus.in_valid && model_ready() && !flush;
        hold = m_valid && !bus.out_ready;
        n_d1 = resolve(bus.in_rs_addr, bus.in_rs_data);
        n_d2 = bus.in_use_imm ? bus.in_imm : resolve(bus.in_rt_addr, bus.in_rt_data);
        s_d1 = (FWD && hits(mwb_reg_write, mwb_dest_addr, m_rs)) ? mwb_data : m_d1;
        s_d2 = (FWD && !m_imm && hits(mwb_reg_write, mwb_dest_addr, m_rt)) ? mwb_data : m_d2;
        if (f) begin
            m_valid = 1'b0; m_rw = 1'b0;
        end else if (take) begin
            m_valid = 1'b1; m_alu = bus.in_alu_sel; m_d1 = n_d1; m_d2 = n_d2;
            m_shamt = bus.in_shamt; m_dest = bus.in_dest_addr; m_rw = bus.in_reg_write;
            m_ld = bus.in_is_load; m_rs = bus.in_rs_addr; m_rt = bus.in_rt_addr;
            m_imm = bus.in_use_imm;
        end else if (hold) begin
            m_d1 = s_d1; m_d2 = s_d2;
        end else begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.in_valid = 1'b0; bus.in_alu_sel = ADD_ALU_Sel; bus.in_rs_addr = 5'd0;
        bus.in_rt_addr = 5'd0; bus.in_rs_data = 32'd0; bus.in_rt_data = 32'd0;
        bus.in_imm = 32'd0; bus.in_use_imm = 1'b0; bus.in_shamt = 5'd0;
        bus.in_dest_addr = 5'd0; bus.in_reg_write = 1'b0; bus.in_is_load = 1'b0;
        bus.out_ready = 1'b1; flush = 1'b0;
        exm_reg_write = 1'b0; exm_dest_addr = 5'd0; exm_data = 32'd0; exm_load = 1'b0;
        mwb_reg_write = 1'b0; mwb_dest_addr = 5'd0; mwb_data = 32'd0;
    endtask

    task automatic set_instr(alu_sel_t alu, logic [4:0] rs, logic [4:0] rt, logic [31:0] rsd,
                             logic [31:0] rtd, logic [31:0] imm, logic use_imm, logic [4:0] dest,
                             logic rw, logic ld);
        bus.in_valid = 1'b1; bus.in_alu_sel = alu; bus.in_rs_addr = rs; bus.in_rt_addr = rt;
        bus.in_rs_data = rsd; bus.in_rt_data = rtd; bus.in_imm = imm; bus.in_use_imm = use_imm;
        bus.in_shamt = 5'd0; bus.in_dest_addr = dest; bus.in_reg_write = rw; bus.in_is_load = ld;
    endtask

    task automatic drain();
        drive_idle();
        tick();
        tick();
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if ({bus.out_valid, bus.reg_write, bus.is_load} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b expected 000", {bus.out_valid, bus.reg_write, bus.is_load});
        end
        tests_run++;
        if (bus.alu_sel !== ADD_ALU_Sel) begin
            tests_failed++;
            $display("FAIL reset_alu_sel: got %0d expected %0d", bus.alu_sel, ADD_ALU_Sel);
        end
        tests_run++;
        if ({bus.data_in1, bus.data_in2, bus.shamt, bus.dest_addr} !== 74'd0) begin
            tests_failed++;
            $display("FAIL reset_data: got %h %h %h %h expected zeros",
                     bus.data_in1, bus.data_in2, bus.shamt, bus.dest_addr);
        end
        tests_run++;
        if (bus.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        end
    endtask

    task automatic test_back_to_back();
        drain();
        set_instr(ADD_ALU_Sel, 5'd1, 5'd2, 32'h3, 32'h4, 32'h0, 1'b0, 5'd3, 1'b1, 1'b0);
        tick();
        tests_run++;
        if ({bus.out_valid, bus.data_in1, bus.data_in2} !== {1'b1, 32'h3, 32'h4}) begin
            tests_failed++;
            $display("FAIL b2b_add: got %b %h %h expected 1 3 4", bus.out_valid, bus.data_in1, bus.data_in2);
        end
        set_instr(SUB_ALU_Sel, 5'd3, 5'd1, 32'h99, 32'h3, 32'h0, 1'b0, 5'd4, 1'b1, 1'b0);
        exm_reg_write = 1'b1; exm_dest_addr = 5'd3; exm_data = 32'h10;
        #1;
        tests_run++;
        if (bus.in_ready !== FWD) begin
            tests_failed++;
            $display("FAIL b2b_ready: got %b expected %b", bus.in_ready, FWD);
        end
        tick();
        tests_run++;
        if ({bus.out_valid, bus.data_in1} !== (FWD ? {1'b1, 32'h10} : {1'b0, m_d1})) begin
            tests_failed++;
            $display("FAIL b2b_sub_fwd: got %b %h expected valid=%b", bus.out_valid, bus.data_in1, FWD);
        end
        exm_reg_write = 1'b0;
        mwb_reg_write = 1'b1; mwb_dest_addr = 5'd3; mwb_data = 32'h10;
        tick();
        mwb_reg_write = 1'b0; bus.in_rs_data = 32'h10;
        tick();
        tests_run++;
        if ({bus.out_valid, bus.alu_sel, bus.data_in1, bus.data_in2} !== {1'b1, SUB_ALU_Sel, 32'h10, 32'h3}) begin
            tests_failed++;
            $display("FAIL b2b_sub_final: got %b %0d %h %h expected 1 SUB 10 3",
                     bus.out_valid, bus.alu_sel, bus.data_in1, bus.data_in2);
        end
    endtask

    task automatic test_load_use();
        drain();
        set_instr(ADD_ALU_Sel, 5'd1, 5'd0, 32'h1, 32'h0, 32'h0, 1'b0, 5'd2, 1'b1, 1'b0);
        tick();
        set_instr(OR_ALU_Sel, 5'd5, 5'd0, 32'h0, 32'h0, 32'hF, 1'b1, 5'd6, 1'b1, 1'b0);
        exm_reg_write = 1'b1; exm_dest_addr = 5'd5; exm_data = 32'hDEAD; exm_load = 1'b1;
        #1;
        tests_run++;
        if (bus.in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_use_stall: got %b expected 0", bus.in_ready);
        end
        tick();
        tests_run++;
        if (bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_use_bubble: got %b expected 0", bus.out_valid);
        end
        exm_reg_write = 1'b0; exm_load = 1'b0;
        mwb_reg_write = 1'b1; mwb_dest_addr = 5'd5; mwb_data = 32'hA5;
        #1;
        tests_run++;
        if (bus.in_ready !== FWD) begin
            tests_failed++;
            $display("FAIL load_use_release: got %b expected %b", bus.in_ready, FWD);
        end
        tick();
        tests_run++;
        if ({bus.out_valid, bus.data_in1} !== (FWD ? {1'b1, 32'hA5} : {1'b0, m_d1})) begin
            tests_failed++;
            $display("FAIL load_use_mwb: got %b %h expected valid=%b data a5", bus.out_valid, bus.data_in1, FWD);
        end
        mwb_reg_write = 1'b0; bus.in_rs_data = 32'hA5;
        tick();
        tests_run++;
        if ({bus.out_valid, bus.data_in1, bus.data_in2} !== {1'b1, 32'hA5, 32'hF}) begin
            tests_failed++;
            $display("FAIL load_use_final: got %b %h %h expected 1 a5 f", bus.out_valid, bus.data_in1, bus.data_in2);
        end
    endtask

    task automatic test_priority();
        drain();
        set_instr(ADD_ALU_Sel, 5'd7, 5'd0, 32'h3, 32'h44, 32'h0, 1'b0, 5'd8, 1'b1, 1'b0);
        exm_reg_write = 1'b1; exm_dest_addr = 5'd7; exm_data = 32'h1;
        mwb_reg_write = 1'b1; mwb_dest_addr = 5'd7; mwb_data = 32'h2;
        tick();
        tests_run++;
        if ({bus.out_valid, bus.data_in1} !== (FWD ? {1'b1, 32'h1} : {1'b0, m_d1})) begin
            tests_failed++;
            $display("FAIL prio_exm_over_mwb: got %b %h expected valid=%b data 1", bus.out_valid, bus.data_in1, FWD);
        end
        drain();
        set_instr(ADD_ALU_Sel, 5'd0, 5'd0, 32'h77, 32'h66, 32'h0, 1'b0, 5'd8, 1'b1, 1'b0);
        exm_reg_write = 1'b1; exm_dest_addr = 5'd0; exm_data = 32'hFF;
        mwb_reg_write = 1'b1; mwb_dest_addr = 5'd0; mwb_data = 32'hFF;
        #1;
        tests_run++;
        if (bus.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL r0_no_hazard: got %b expected 1", bus.in_ready);
        end
        tick();
        tests_run++;
        if ({bus.data_in1, bus.data_in2} !== {32'h77, 32'h66}) begin
            tests_failed++;
            $display("FAIL r0_not_forwarded: got %h %h expected 77 66", bus.data_in1, bus.data_in2);
        end
    endtask

    task automatic test_hold();
        drain();
        set_instr(AND_ALU_Sel, 5'd0, 5'd2, 32'h0, 32'h11, 32'h0, 1'b0, 5'd6, 1'b1, 1'b0);
        tick();
        set_instr(XOR_ALU_Sel, 5'd1, 5'd3, 32'h8, 32'h9, 32'h0, 1'b0, 5'd4, 1'b1, 1'b0);
        bus.out_ready = 1'b0;
        mwb_reg_write = 1'b1; mwb_dest_addr = 5'd2; mwb_data = 32'h55;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++;
            if (bus.in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL hold_in_ready[%0d]: got %b expected 0", i, bus.in_ready);
            end
            tick();
        end
        tests_run++;
        if ({bus.out_valid, bus.alu_sel, bus.data_in1, bus.data_in2} !==
            {1'b1, AND_ALU_Sel, 32'h0, (FWD ? 32'h55 : 32'h11)}) begin
            tests_failed++;
            $display("FAIL hold_snoop: got %b %0d %h %h expected rt=%h", bus.out_valid, bus.alu_sel,
                     bus.data_in1, bus.data_in2, (FWD ? 32'h55 : 32'h11));
        end
        drive_idle();
        tick();
        tests_run++;
        if (bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold_consume: got %b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_flush();
        drain();
        set_instr(ADD_ALU_Sel, 5'd1, 5'd2, 32'h1, 32'h2, 32'h0, 1'b0, 5'd9, 1'b1, 1'b0);
        tick();
        set_instr(SUB_ALU_Sel, 5'd4, 5'd0, 32'h1, 32'h2, 32'h0, 1'b1, 5'd9, 1'b1, 1'b0);
        exm_reg_write = 1'b1; exm_dest_addr = 5'd4; exm_load = 1'b1;
        bus.out_ready = 1'b0; flush = 1'b1;
        #1;
        tests_run++;
        if (bus.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_in_ready: got %b expected 1", bus.in_ready);
        end
        tick();
        tests_run++;
        if ({bus.out_valid, bus.reg_write} !== 2'b00) begin
            tests_failed++;
            $display("FAIL flush_clear: got %b%b expected 00", bus.out_valid, bus.reg_write);
        end
        drive_idle();
    endtask

    task automatic test_reset_hold();
        drain();
        set_instr(SLT_ALU_Sel, 5'd1, 5'd2, 32'h123, 32'h456, 32'h0, 1'b0, 5'd9, 1'b1, 1'b1);
        tick();
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        tests_run++;
        if ({bus.out_valid, bus.reg_write, bus.is_load, bus.data_in1, bus.dest_addr} !== 40'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_hold: got %b %b %b %h %h expected zeros", bus.out_valid,
                     bus.reg_write, bus.is_load, bus.data_in1, bus.dest_addr);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive_idle();
        tick();
        tests_run++;
        if (bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_drops_entry: got %b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_no_fwd_stall();
        drain();
        set_instr(ADD_ALU_Sel, 5'd3, 5'd0, 32'h99, 32'h0, 32'h1, 1'b1, 5'd10, 1'b1, 1'b0);
        exm_reg_write = 1'b1; exm_dest_addr = 5'd3; exm_data = 32'h30;
        #1;
        tests_run++;
        if (bus.in_ready !== FWD) begin
            tests_failed++;
            $display("FAIL nofwd_exm_stall: got %b expected %b", bus.in_ready, FWD);
        end
        tick();
        exm_reg_write = 1'b0;
        mwb_reg_write = 1'b1; mwb_dest_addr = 5'd3; mwb_data = 32'h30;
        #1;
        tests_run++;
        if (bus.in_ready !== FWD) begin
            tests_failed++;
            $display("FAIL nofwd_mwb_stall: got %b expected %b", bus.in_ready, FWD);
        end
        tick();
        mwb_reg_write = 1'b0; bus.in_rs_data = 32'h30;
        #1;
        tests_run++;
        if (bus.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL nofwd_retired: got %b expected 1", bus.in_ready);
        end
        tick();
        tests_run++;
        if ({bus.out_valid, bus.data_in1} !== {1'b1, 32'h30}) begin
            tests_failed++;
            $display("FAIL nofwd_operand: got %b %h expected 1 30", bus.out_valid, bus.data_in1);
        end
    endtask

    task automatic test_random();
        drain();
        for (int i = 0; i < 600; i++) begin
            bus.in_valid = ($urandom_range(0, 9) < 8);
            bus.in_alu_sel = alu_sel_t'($urandom_range(0, 10));
            bus.in_rs_addr = 5'($urandom_range(0, 3));
            bus.in_rt_addr = 5'($urandom_range(0, 3));
            bus.in_rs_data = $urandom; bus.in_rt_data = $urandom; bus.in_imm = $urandom;
            bus.in_use_imm = $urandom_range(0, 1);
            bus.in_shamt = 5'($urandom_range(0, 31));
            bus.in_dest_addr = 5'($urandom_range(0, 31));
            bus.in_reg_write = $urandom_range(0, 1); bus.in_is_load = $urandom_range(0, 1);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 19) == 0);
            exm_reg_write = $urandom_range(0, 1); exm_dest_addr = 5'($urandom_range(0, 3));
            exm_data = $urandom; exm_load = ($urandom_range(0, 2) == 0);
            mwb_reg_write = $urandom_range(0, 1); mwb_dest_addr = 5'($urandom_range(0, 3));
            mwb_data = $urandom;
            #1;
            tests_run++;
            if (bus.in_ready !== model_ready()) begin
                tests_failed++;
                $display("FAIL rand_in_ready[%0d]: got %b expected %b", i, bus.in_ready, model_ready());
            end
            tick();
            tests_run++;
            if (bus.out_valid !== m_valid) begin
                tests_failed++;
                $display("FAIL rand_out_valid[%0d]: got %b expected %b", i, bus.out_valid, m_valid);
            end else if (m_valid && ({bus.alu_sel, bus.data_in1, bus.data_in2, bus.shamt, bus.dest_addr,
                                       bus.reg_write, bus.is_load} !==
                                      {m_alu, m_d1, m_d2, m_shamt, m_dest, m_rw, m_ld})) begin
                tests_failed++;
                $display("FAIL rand_payload[%0d]: got %0d %h %h %h %h %b %b expected %0d %h %h %h %h %b %b", i,
                         bus.alu_sel, bus.data_in1, bus.data_in2, bus.shamt, bus.dest_addr, bus.reg_write,
                         bus.is_load, m_alu, m_d1, m_d2, m_shamt, m_dest, m_rw, m_ld);
            end
        end
        drive_idle();
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_back_to_back();
        test_load_use();
        test_priority();
        test_hold();
        test_flush();
        test_reset_hold();
        test_no_fwd_stall();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mips_id_ex_stage.md
# mips_id_ex_stage

ID/EX pipeline stage that feeds the MIPS ALU. It accepts decoded instructions from the decode stage and resolves operand hazards. Results are forwarded from EX/MEM and MEM/WB. It presents registered `alu_sel`, `data_in1`, `data_in2`, `shamt` and destination info to the ALU through a single-entry valid/ready pipeline register, and supports stall and flush.

## Interface
Parameters:
- `Data_Width`, 32, operand width (package constant)
- `Reg_Addr_Width`, 5, register address width

Ports:
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  decode presents an instruction
- `in_ready`  out  1  stage accepts the instruction this cycle
- `in_alu_sel`  in  alu_sel_t  ALU operation
- `in_rs_addr`, `in_rt_addr`  in  5  source register addresses
- `in_rs_data`, `in_rt_data`  in  Data_Width  register-file read values
- `in_imm`  in  Data_Width  sign/zero-extended immediate
- `in_use_imm`  in  1  select `in_imm` as operand 2
- `in_shamt`  in  5  shift amount
- `in_dest_addr`  in  5  destination register
- `in_reg_write`  in  1  instruction writes a register
- `in_is_load`  in  1  instruction is a load (forwarded downstream)
- `flush`  in  1  synchronous kill of stage contents and current input
- `exm_reg_write`, `exm_dest_addr`, `exm_data`, `exm_load`  in  1/5/Data_Width/1  EX/MEM writer
- `mwb_reg_write`, `mwb_dest_addr`, `mwb_data`  in  1/5/Data_Width  MEM/WB writer
- `out_valid`  out  1  ALU inputs valid
- `out_ready`  in  1  EX consumes this cycle
- `alu_sel`, `data_in1`, `data_in2`, `shamt`  out  alu_sel_t/Data_Width/Data_Width/5  to ALU
- `dest_addr`, `reg_write`, `is_load`  out  5/1/1  carried to EX/MEM

## Operation
- Operand 1 is rs. Operand 2 is `in_use_imm ? in_imm : rt`. rt is a hazard source only when `!in_use_imm`.
- Forward match: writer `reg_write=1` and `dest_addr == src` and `src != 0`. Priority is EX/MEM, then MEM/WB, then register file.
- Load-use hazard: an EX/MEM match with `exm_load=1` forces `in_ready=0` for that cycle; no capture takes place.
- `in_ready = !hazard && (!out_valid || out_ready)`. Capture happens on `in_valid && in_ready`.
- Held entry (`out_valid && !out_ready`): each cycle a matching `mwb` write replaces the held operand for rs, and for rt when not immediate. Held values never go stale.
- Flush: the next edge clears `out_valid` and `reg_write`. The input in the same cycle is discarded; `in_ready` reads 1. Flush overrides hazard and hold.
- Register 0 is never forwarded, never causes a hazard, and always reads the register-file value.

## Timing
- Latency 1 cycle from capture to `out_valid`. Throughput 1 per cycle with no hazards.
- Reset (async assert, sync release): `out_valid=0`, `reg_write=0`, `is_load=0`, `alu_sel=ADD_ALU_Sel`, all data/address outputs 0.
- `out_valid` falls after a consume without a new capture. A consume and a capture in the same cycle keep `out_valid=1` with new contents.
- A load-use stall inserts exactly one bubble. The following cycle forwards from MEM/WB.
- Reset during a hold drops the entry; no output is produced.

## Configuration
- `MIPS_FORWARDING_EN` defined: forwarding and held-entry snoop behave as described.
- Not defined:
  - Operands come only from the register file.
  - Any EX/MEM or MEM/WB match is a hazard and forces `in_ready=0` until the writer retires.
  - The snoop logic is absent.
  - Results stay functionally identical; CPI increases.

## Structure
- Shared package: `alu_sel_t`, `Data_Width`, `Reg_Addr_Width`, and `fwd_sel_t` (`FWD_NONE`, `FWD_EXM`, `FWD_MWB`).
- Sub-module `mips_fwd_unit`: compare logic plus the 3:1 mux for one operand. It is instantiated twice, for rs and rt.

## Test plan
- Back-to-back ADD r3=r1+r2, then SUB r4=r3-r1, with `exm_data`=0x10: SUB `data_in1`=0x10, no bubble, `out_valid` held 1.
- Load r5 in EX/MEM (`exm_load=1`), then OR using r5: `in_ready=0` for one cycle. Next cycle `mwb_data`=0xA5 gives `data_in1`=0xA5.
- EX/MEM and MEM/WB both writing r7 (0x1 / 0x2) → 0x1 selected. A writer targeting r0 with 0xFF is ignored; the register-file value is used.
- `out_ready=0` for 3 cycles while `mwb` writes r2=0x55 → held `data_in2` updates to 0x55. `in_ready=0` during the hold.
- `flush` together with `in_valid` → next cycle `out_valid=0`, `reg_write=0`. Assert `rst_n`=0 mid-hold → outputs reach reset values immediately.
- Build without `MIPS_FORWARDING_EN`, EX/MEM writing r3, then r3 consumer: `in_ready=0` until the writer leaves MEM/WB. The operand then equals the register-file value.
